// File: rtl/packet_gen_multi.sv
// rtl/packet_gen_multi.sv - multi-packet symbol streamer from the packet ROM to the FSK modulator
//
// Purpose: reads pkt_len symbols per packet from a combinational symbol ROM and
// hands them, one registered symbol at a time, to the modulator, advancing on
// each sym_done. Supports a packet repeat count, continuous mode, a fixed
// inter-packet gap with the modulator disabled, abort, and busy/done status.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst       synchronous reset, active-high
//   go        one-cycle start pulse, honoured only when idle
//   abort     level, ends any burst and returns to idle without done
//   cont      sampled at go: repeat packets until abort
//   pkt_len   sampled at go: symbols per packet, 0 = 2**ADDR_W
//   num_pkts  sampled at go: packets per burst, 0 = 1
//   sym_done  modulator has consumed the current symbol
//   rom_addr  symbol index into the ROM (current symbol counter)
//   rom_data  ROM symbol at rom_addr
//   sym_val   registered symbol to the modulator
//   tx_en     modulator enable
//   busy      high whenever not idle
//   done      one-cycle pulse on normal burst completion
//   pkt_cnt   packets fully sent in the current burst
module packet_gen_multi #(
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 16,
  parameter bit INVERT_SYM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic              cont,
  input  logic [ADDR_W-1:0] pkt_len,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic              sym_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              sym_val,
  output logic              tx_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_TAIL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;        // one bit wider so length 0 can mean 2**ADDR_W
  logic              cont_q, cont_d;
  logic [CNT_W-1:0]  pkts_q, pkts_d;
  logic [ADDR_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sym_val_q, sym_val_d;
  logic              last_sym;

  assign last_sym = ({1'b0, sym_cnt_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cont_d    = cont_q;
    pkts_d    = pkts_q;
    sym_cnt_d = sym_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    gap_d     = gap_q;
    sym_val_d = sym_val_q;

    if ((state_q != S_IDLE) && abort) begin
      // Abort wins over sym_done and go; counters are left for inspection.
      state_d   = S_IDLE;
      sym_val_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            // Burst configuration is captured with the go pulse itself.
            len_d   = (pkt_len == '0) ? LEN_MAX : {1'b0, pkt_len};
            cont_d  = cont;
            pkts_d  = (num_pkts == '0) ? CNT_ONE : num_pkts;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          sym_cnt_d = '0;
          pkt_cnt_d = '0;
          state_d   = S_TX;
        end
        S_TX: begin
          sym_val_d = rom_data ^ INVERT_SYM;
          if (sym_done) begin
            if (last_sym) begin
              pkt_cnt_d = pkt_cnt_q + CNT_ONE;
              state_d   = S_TAIL;
            end else begin
              sym_cnt_d = sym_cnt_q + ADDR_ONE;
            end
          end
        end
        S_TAIL: begin
          // pkt_cnt_q already includes the packet just finished.
          if (cont_q || (pkt_cnt_q < pkts_q)) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_FIN;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            sym_cnt_d = '0;
            state_d   = S_TX;
          end else begin
            gap_d = gap_q + GAP_ONE;
          end
        end
        S_FIN: begin
          sym_val_d = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          sym_val_d = 1'b0;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cont_q    <= 1'b0;
      pkts_q    <= '0;
      sym_cnt_q <= '0;
      pkt_cnt_q <= '0;
      gap_q     <= '0;
      sym_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cont_q    <= cont_d;
      pkts_q    <= pkts_d;
      sym_cnt_q <= sym_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_q     <= gap_d;
      sym_val_q <= sym_val_d;
    end
  end

  assign rom_addr = sym_cnt_q;
  assign sym_val  = sym_val_q;
  assign tx_en    = (state_q == S_TX) || (state_q == S_TAIL);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_packet_gen_multi.sv
// tb/tb_packet_gen_multi.sv - randomized self-checking bench for packet_gen_multi
module tb_packet_gen_multi;

  localparam int GAP = 16;

  logic       clk;
  logic       rst;
  logic       go;
  logic       abort;
  logic       cont;
  logic [7:0] pkt_len;
  logic [7:0] num_pkts;
  logic       sym_done;
  logic [7:0] rom_addr;
  logic       rom_data;
  logic       sym_val;
  logic       tx_en;
  logic       busy;
  logic       done;
  logic [7:0] pkt_cnt;

  logic rom [256];
  assign rom_data = rom[rom_addr];

  packet_gen_multi dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .abort    (abort),
    .cont     (cont),
    .pkt_len  (pkt_len),
    .num_pkts (num_pkts),
    .sym_done (sym_done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .sym_val  (sym_val),
    .tx_en    (tx_en),
    .busy     (busy),
    .done     (done),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Modulator model: consumes a symbol only after it has sat in sym_val for a
  // full cycle, optionally throwing stray pulses while tx_en is low.
  bit sd_en    = 1'b1;
  bit sd_fixed = 1'b0;
  bit stray_en = 1'b0;
  int sd_hold  = 0;
  bit prev_tx  = 1'b0;

  initial begin
    sym_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sym_done = 1'b0;
      if (sd_hold > 0) begin
        sd_hold--;
      end else if (tx_en && prev_tx && sd_en) begin
        sym_done = 1'b1;
        sd_hold  = sd_fixed ? 2 : int'($urandom_range(1, 3));
      end else if (!tx_en && stray_en && ($urandom_range(0, 2) == 0)) begin
        sym_done = 1'b1;
        sd_hold  = 1;
      end
      prev_tx = tx_en;
    end
  end

  // Reference model: a burst is a list of packets, each the ROM symbols
  // 0..len-1 inverted; checked symbol by symbol at each consumption.
  int  m_len, m_target, m_idx, m_pkts, consumed, done_cnt, gap_run, gaps_seen;
  bit  m_cont, active, seen_tx;
  logic exp_sym;
  bit  obs_syms[$];

  initial begin
    done_cnt  = 0;
    gaps_seen = 0;
    active    = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      active  = 1'b0;
      m_idx   = 0;
      m_pkts  = 0;
      gap_run = 0;
      seen_tx = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        expect_eq("done_pkt_cnt", pkt_cnt, m_pkts % 256);
        expect_eq("done_pkt_target", m_pkts, m_target);
        expect_eq("done_not_cont", m_cont, 0);
      end
      if (busy && tx_en && sym_done && !abort && active) begin
        exp_sym = ~rom[m_idx];
        expect_eq("sym_addr", rom_addr, m_idx);
        expect_eq("sym_val", sym_val, exp_sym);
        expect_eq("sym_pkt_cnt", pkt_cnt, m_pkts % 256);
        obs_syms.push_back(sym_val);
        consumed++;
        m_idx++;
        if (m_idx == m_len) begin
          m_idx = 0;
          m_pkts++;
        end
      end
      if (!busy && go && !abort) begin
        m_len    = (pkt_len == 0) ? 256 : int'(pkt_len);
        m_target = (num_pkts == 0) ? 1 : int'(num_pkts);
        m_cont   = cont;
        m_idx    = 0;
        m_pkts   = 0;
        consumed = 0;
        active   = 1'b1;
        obs_syms.delete();
      end
      if (!busy) begin
        gap_run = 0;
        seen_tx = 1'b0;
      end else if (tx_en) begin
        if (seen_tx && gap_run > 0) begin
          expect_eq("gap_len", gap_run, GAP);
          gaps_seen++;
        end
        gap_run = 0;
        seen_tx = 1'b1;
      end else if (seen_tx) begin
        gap_run++;
      end
    end
  end

  task automatic start_burst(input int len, input int num, input bit c, input int load_addr);
    @(posedge clk);
    #1;
    pkt_len  = 8'(len);
    num_pkts = 8'(num);
    cont     = c;
    go       = 1'b1;
    @(negedge clk);
    expect_eq("go_cycle_idle", busy, 0);
    @(posedge clk);
    #1;
    go       = 1'b0;
    pkt_len  = 8'($urandom);
    num_pkts = 8'($urandom);
    cont     = 1'($urandom);
    @(negedge clk);
    expect_eq("load_busy", busy, 1);
    expect_eq("load_tx_en", tx_en, 0);
    expect_eq("load_addr_hold", rom_addr, load_addr);
    @(negedge clk);
    expect_eq("tx_entry", tx_en, 1);
    expect_eq("tx_addr0", rom_addr, 0);
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    for (int n = 0; n < max_cycles && busy; n++) @(negedge clk);
    expect_eq(tag, busy, 0);
  endtask

  int d0;
  bit reached;

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; cont = 1'b0;
    pkt_len = '0; num_pkts = '0;
    for (int i = 0; i < 256; i++) rom[i] = 1'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_tx_en", tx_en, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_pkt_cnt", pkt_cnt, 0);
    expect_eq("rst_sym_val", sym_val, 0);
    expect_eq("rst_addr", rom_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: fixed ROM pattern, sym_done every third cycle
    rom[0] = 1'b1; rom[1] = 1'b0; rom[2] = 1'b1; rom[3] = 1'b1;
    sd_fixed = 1'b1;
    d0 = done_cnt;
    start_burst(4, 1, 1'b0, 0);
    wait_idle(200, "t1_idle");
    expect_eq("t1_done", done_cnt - d0, 1);
    expect_eq("t1_pkt_cnt", pkt_cnt, 1);
    expect_eq("t1_nsyms", obs_syms.size(), 4);
    if (obs_syms.size() == 4)
      expect_eq("t1_seq", {obs_syms[0], obs_syms[1], obs_syms[2], obs_syms[3]}, 4'b0100);
    expect_eq("t1_idle_sym", sym_val, 0);
    sd_fixed = 1'b0;

    // T2: length 0 means a full 256-symbol packet
    for (int i = 0; i < 256; i++) rom[i] = 1'($urandom);
    d0 = done_cnt;
    start_burst(0, 1, 1'b0, 3);
    wait_idle(3000, "t2_idle");
    expect_eq("t2_consumed", consumed, 256);
    expect_eq("t2_done", done_cnt - d0, 1);
    expect_eq("t2_addr_end", rom_addr, 255);

    // T3: three packets with gaps
    d0 = done_cnt;
    gaps_seen = 0;
    start_burst(8, 3, 1'b0, 255);
    wait_idle(1000, "t3_idle");
    expect_eq("t3_done", done_cnt - d0, 1);
    expect_eq("t3_pkt_cnt", pkt_cnt, 3);
    expect_eq("t3_consumed", consumed, 24);
    expect_eq("t3_gaps", gaps_seen, 2);

    // T5: go during TX and GAP ignored, stray sym_done outside TX ignored
    stray_en = 1'b1;
    d0 = done_cnt;
    start_burst(6, 3, 1'b0, 7);
    reached = 1'b0;
    for (int n = 0; n < 500 && !reached; n++) begin
      @(negedge clk);
      reached = tx_en && (rom_addr == 3);
    end
    expect_eq("t5_reach_tx", reached, 1);
    @(posedge clk); #1 go = 1'b1; pkt_len = 8'd2; num_pkts = 8'd9;
    @(posedge clk); #1 go = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 500 && !reached; n++) begin
      @(negedge clk);
      reached = busy && !tx_en && (pkt_cnt == 1);
    end
    expect_eq("t5_reach_gap", reached, 1);
    @(posedge clk); #1 go = 1'b1; pkt_len = 8'd1; num_pkts = 8'd1;
    @(posedge clk); #1 go = 1'b0;
    wait_idle(1000, "t5_idle");
    expect_eq("t5_done", done_cnt - d0, 1);
    expect_eq("t5_pkt_cnt", pkt_cnt, 3);
    expect_eq("t5_consumed", consumed, 18);
    repeat (20) @(negedge clk);
    expect_eq("t5_idle_stray_addr", rom_addr, 5);
    stray_en = 1'b0;

    // T4: continuous mode, abort mid-symbol of packet 13
    d0 = done_cnt;
    start_burst(5, 7, 1'b1, 5);
    reached = 1'b0;
    for (int n = 0; n < 3000 && !reached; n++) begin
      @(negedge clk);
      reached = tx_en && (pkt_cnt == 12) && (rom_addr == 2);
    end
    expect_eq("t4_reach", reached, 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    expect_eq("t4_busy", busy, 0);
    expect_eq("t4_tx_en", tx_en, 0);
    expect_eq("t4_pkt_cnt", pkt_cnt, 12);
    repeat (3) @(negedge clk);
    expect_eq("t4_no_done", done_cnt - d0, 0);

    // T6: reset in the middle of TX, then a clean restart
    start_burst(10, 2, 1'b0, int'(rom_addr));
    reached = 1'b0;
    for (int n = 0; n < 500 && !reached; n++) begin
      @(negedge clk);
      reached = tx_en && (rom_addr == 3);
    end
    expect_eq("t6_reach", reached, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    expect_eq("t6_tx_en", tx_en, 0);
    expect_eq("t6_busy", busy, 0);
    expect_eq("t6_done", done, 0);
    expect_eq("t6_pkt_cnt", pkt_cnt, 0);
    expect_eq("t6_sym_val", sym_val, 0);
    expect_eq("t6_addr", rom_addr, 0);
    d0 = done_cnt;
    start_burst(4, 1, 1'b0, 0);
    wait_idle(300, "t6_idle");
    expect_eq("t6_restart_done", done_cnt - d0, 1);
    expect_eq("t6_restart_pkts", pkt_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
